// File: rtl/lsu_dmem.sv
// Purpose: MEM-stage load/store unit with an integrated word-organised data memory.
// Latency: stores update the array at the accepting edge; load data is valid 1 cycle after the request edge.
// Backpressure: stall freezes the output registers and blocks array writes; there is no other flow control.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset (outputs only, array not cleared)
//   addr, wdata       byte address and store data from EX/MEM
//   mem_read/write    load / store request; both set means store only
//   funct3            access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   stall             hold MEM/WB, suppress all effects this cycle
//   rdata, load_valid registered, extended load result and its qualifier
//   misaligned        registered flag: previous accepted access was misaligned
module lsu_dmem #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic        stall,
    output logic [31:0] rdata,
    output logic        load_valid,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx_c;
    logic [1:0]    off_c;
    logic          size_half_c;
    logic          size_word_c;
    logic          unsigned_c;
    logic          mis_c;
    logic          acc_c;
    logic          wr_en_c;
    logic [3:0]    be_c;
    logic [31:0]   wlane_c;
    logic [31:0]   rd_word_c;
    logic [31:0]   shifted_c;
    logic [31:0]   load_ext_c;

    logic [31:0]   rdata_q, rdata_d;
    logic          load_valid_q, load_valid_d;
    logic          misaligned_q, misaligned_d;

    // Upper address bits are deliberately ignored: the array aliases.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign idx_c       = addr[AW+1:2];
    assign off_c       = addr[1:0];
    assign size_half_c = (funct3[1:0] == 2'b01);
    assign size_word_c = funct3[1];
    assign unsigned_c  = funct3[2];

    assign mis_c   = (size_half_c & off_c[0]) | (size_word_c & (off_c != 2'b00));
    assign acc_c   = (mem_read | mem_write) & ~stall;
    // rst gating drops a store that coincides with an edge while reset is held.
    assign wr_en_c = acc_c & mem_write & ~mis_c & ~rst;

    // Lane enables and lane-replicated write data, so each lane just takes its own slice.
    always_comb begin
        be_c    = 4'b0000;
        wlane_c = wdata;
        if (size_word_c) begin
            be_c    = 4'b1111;
            wlane_c = wdata;
        end else if (size_half_c) begin
            be_c    = off_c[1] ? 4'b1100 : 4'b0011;
            wlane_c = {2{wdata[15:0]}};
        end else begin
            be_c    = 4'b0001 << off_c;
            wlane_c = {4{wdata[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int l = 0; l < 4; l++) begin
                if (be_c[l]) begin
                    mem_q[idx_c][8*l +: 8] <= wlane_c[8*l +: 8];
                end
            end
        end
    end

    // Load path reads the pre-edge word and shifts the addressed byte/half down to bit 0.
    assign rd_word_c = mem_q[idx_c];
    assign shifted_c = rd_word_c >> {off_c, 3'b000};

    always_comb begin
        if (size_word_c) begin
            load_ext_c = rd_word_c;
        end else if (size_half_c) begin
            load_ext_c = {{16{~unsigned_c & shifted_c[15]}}, shifted_c[15:0]};
        end else begin
            load_ext_c = {{24{~unsigned_c & shifted_c[7]}}, shifted_c[7:0]};
        end
    end

    always_comb begin
        rdata_d      = rdata_q;
        load_valid_d = load_valid_q;
        misaligned_d = misaligned_q;
        if (!stall) begin
            rdata_d      = 32'h0;
            load_valid_d = 1'b0;
            misaligned_d = 1'b0;
            if (acc_c) begin
                if (mis_c) begin
                    misaligned_d = 1'b1;
                end else if (mem_read && !mem_write) begin
                    rdata_d      = load_ext_c;
                    load_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q      <= 32'h0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign rdata      = rdata_q;
    assign load_valid = load_valid_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Purpose: self-checking bench for lsu_dmem: vector table driven through a scoreboard queue,
// Latency: each vector is driven on the falling edge and its expectation popped 1 ns after the next rising edge.
// Backpressure: stall vectors expect the output registers to hold their previous values.
module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] rdata;
    logic        load_valid;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic        stall;
        logic [31:0] exp_rdata;
        logic        exp_lv;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        lv;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    lsu_dmem #(.DEPTH_WORDS(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .stall      (stall),
        .rdata      (rdata),
        .load_valid (load_valid),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                                input logic wr, input logic [2:0] f3, input logic st,
                                input logic [31:0] er, input logic elv, input logic emis);
        vec_t v;
        v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr; v.f3 = f3; v.stall = st;
        v.exp_rdata = er; v.exp_lv = elv; v.exp_mis = emis;
        return v;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic [2:0] f3, input logic st);
        addr = a; wdata = wd; mem_read = rd; mem_write = wr; funct3 = f3; stall = st;
    endtask

    initial begin
        exp_t e;
        drive(32'h0, 32'h0, 1'b0, 1'b0, F_W, 1'b0);

        //            addr          wdata         rd wr f3    st  exp_rdata     lv mis
        vecs.push_back(mk(32'h40,   32'hDEADBEEF, 0, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h40,   32'h0,        1, 0, F_W,  0, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(32'h80,   32'h0,        0, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h81,   32'h12345685, 0, 1, F_B,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h80,   32'h0,        1, 0, F_W,  0, 32'h00008500, 1, 0));
        vecs.push_back(mk(32'h81,   32'h0,        1, 0, F_B,  0, 32'hFFFFFF85, 1, 0));
        vecs.push_back(mk(32'h81,   32'h0,        1, 0, F_BU, 0, 32'h00000085, 1, 0));
        vecs.push_back(mk(32'h83,   32'h0000007F, 0, 1, F_B,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h80,   32'h0,        1, 0, F_W,  0, 32'h7F008500, 1, 0));
        vecs.push_back(mk(32'h83,   32'h0,        1, 0, F_B,  0, 32'h0000007F, 1, 0));
        vecs.push_back(mk(32'h80,   32'h0,        1, 0, F_H,  0, 32'hFFFF8500, 1, 0));
        vecs.push_back(mk(32'h82,   32'h0,        1, 0, F_HU, 0, 32'h00007F00, 1, 0));
        vecs.push_back(mk(32'h100,  32'h11112222, 0, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h102,  32'hABCD8001, 0, 1, F_H,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h102,  32'h0,        1, 0, F_H,  0, 32'hFFFF8001, 1, 0));
        vecs.push_back(mk(32'h102,  32'h0,        1, 0, F_HU, 0, 32'h00008001, 1, 0));
        vecs.push_back(mk(32'h100,  32'h0,        1, 0, F_W,  0, 32'h80012222, 1, 0));
        vecs.push_back(mk(32'h40,   32'h12345678, 0, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h41,   32'hFFFFFFFF, 0, 1, F_W,  0, 32'h0,        0, 1));
        vecs.push_back(mk(32'h0,    32'h0,        0, 0, F_W,  1, 32'h0,        0, 1));
        vecs.push_back(mk(32'h40,   32'h0,        1, 0, F_W,  0, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h43,   32'h0,        1, 0, F_H,  0, 32'h0,        0, 1));
        vecs.push_back(mk(32'h101,  32'hFFFFFFFF, 0, 1, F_H,  0, 32'h0,        0, 1));
        vecs.push_back(mk(32'h100,  32'h0,        1, 0, F_W,  0, 32'h80012222, 1, 0));
        vecs.push_back(mk(32'h0,    32'h0,        0, 0, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h200,  32'hCAFEF00D, 1, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h200,  32'h0,        1, 0, F_W,  0, 32'hCAFEF00D, 1, 0));
        vecs.push_back(mk(32'h40,   32'h0,        1, 0, F_W,  0, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h40,   32'h0,        0, 1, F_W,  1, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h40,   32'h0,        0, 1, F_W,  1, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h40,   32'h0,        0, 1, F_W,  1, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h40,   32'h0,        1, 0, F_W,  0, 32'h12345678, 1, 0));
        vecs.push_back(mk(32'h4040, 32'hA5A5A5A5, 0, 1, F_W,  0, 32'h0,        0, 0));
        vecs.push_back(mk(32'h40,   32'h0,        1, 0, F_W,  0, 32'hA5A5A5A5, 1, 0));
        vecs.push_back(mk(32'hFFFF4080, 32'h0,    1, 0, F_W,  0, 32'h7F008500, 1, 0));
        vecs.push_back(mk(32'h83,   32'h0,        1, 0, F_BU, 0, 32'h0000007F, 1, 0));

        // Reset state, applied asynchronously before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset rdata", rdata, 32'h0);
        check("reset load_valid", {31'h0, load_valid}, 32'h0);
        check("reset misaligned", {31'h0, misaligned}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].stall);
            e.id = i; e.rdata = vecs[i].exp_rdata; e.lv = vecs[i].exp_lv; e.mis = vecs[i].exp_mis;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard empty at vec%0d", i);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("vec%0d rdata", e.id), rdata, e.rdata);
                check($sformatf("vec%0d load_valid", e.id), {31'h0, load_valid}, {31'h0, e.lv});
                check($sformatf("vec%0d misaligned", e.id), {31'h0, misaligned}, {31'h0, e.mis});
            end
        end

        // Async reset mid-access: outputs clear between edges, concurrent store is dropped.
        @(negedge clk);
        drive(32'h40, 32'h0, 1'b1, 1'b0, F_W, 1'b0);
        @(posedge clk);
        #1;
        check("pre-reset rdata", rdata, 32'hA5A5A5A5);
        check("pre-reset load_valid", {31'h0, load_valid}, 32'h1);
        drive(32'h40, 32'hFFFFFFFF, 1'b0, 1'b1, F_W, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid-reset rdata", rdata, 32'h0);
        check("mid-reset load_valid", {31'h0, load_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("held-reset rdata", rdata, 32'h0);
        check("held-reset load_valid", {31'h0, load_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h40, 32'h0, 1'b1, 1'b0, F_W, 1'b0);
        @(posedge clk);
        #1;
        check("post-reset rdata", rdata, 32'hA5A5A5A5);
        check("post-reset load_valid", {31'h0, load_valid}, 32'h1);
        check("post-reset misaligned", {31'h0, misaligned}, 32'h0);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0, 1'b0, F_W, 1'b0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard leftover entries: got %0d expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
